// File: rtl/multitap_letter_encoder.sv
// Multi-tap keypad letter encoder: turns debounced keypad strobes into committed
// ASCII letters with idle auto-commit, implicit commit on key change and a case toggle.
module multitap_letter_encoder #(
   parameter int unsigned TIMEOUT_CYCLES  = 12_000_000,
   parameter bit          IMPLICIT_COMMIT = 1'b1,
   parameter bit          LOWER_DEFAULT   = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       strobe,
   input  logic [7:0] cur_key,
   output logic       ready,
   output logic [7:0] data,
   output logic [7:0] preview,
   output logic       pending,
   output logic [1:0] tap,
   output logic       lower_case,
   output logic       word_submit,
   output logic       game_end
);

   // state | meaning
   // IDLE  | no letter being composed, preview is 0x00
   // PEND  | letter composed from key_r/tap_r, timeout counter running
   typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

   localparam int unsigned TW       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   // The strobe is registered before processing, so expiry must fire one cycle
   // early on the counter to land ready exactly TIMEOUT_CYCLES after the strobe.
   localparam int unsigned RELOAD_I = (TIMEOUT_CYCLES >= 2) ? TIMEOUT_CYCLES - 2 : 0;
   localparam logic [TW-1:0] RELOAD = TW'(RELOAD_I);

   logic          stb_q;
   logic [7:0]    key_q;
   state_t        state, state_n;
   logic [2:0]    key_r, key_n;
   logic [1:0]    tap_r, tap_n;
   logic          lower_r, lower_n;
   logic [TW-1:0] tmr, tmr_n;
   logic          ready_n, word_n, game_n;
   logic [7:0]    data_n, preview_n, old_letter;

   logic       is_letter, k_star, k_zero, k_hash, k_game, k_case, accepted;
   logic [2:0] key_idx;

   function automatic logic [7:0] letter_ascii(input logic [2:0] idx, input logic [1:0] t,
                                               input logic lc);
      logic [7:0] base;
      case (idx)
         3'd0:    base = 8'h41;
         3'd1:    base = 8'h44;
         3'd2:    base = 8'h47;
         3'd3:    base = 8'h4A;
         3'd4:    base = 8'h4D;
         3'd5:    base = 8'h50;
         3'd6:    base = 8'h54;
         default: base = 8'h57;
      endcase
      return base + {6'd0, t} + (lc ? 8'h20 : 8'h00);
   endfunction

   function automatic logic [1:0] last_tap(input logic [2:0] idx);
      return (idx == 3'd5 || idx == 3'd7) ? 2'd3 : 2'd2;
   endfunction

   always_comb begin
      is_letter = 1'b0;
      key_idx   = 3'd0;
      k_star    = 1'b0;
      k_zero    = 1'b0;
      k_hash    = 1'b0;
      k_game    = 1'b0;
      k_case    = 1'b0;
      case (key_q)
         8'h84: begin is_letter = 1'b1; key_idx = 3'd0; end
         8'h82: begin is_letter = 1'b1; key_idx = 3'd1; end
         8'h48: begin is_letter = 1'b1; key_idx = 3'd2; end
         8'h44: begin is_letter = 1'b1; key_idx = 3'd3; end
         8'h42: begin is_letter = 1'b1; key_idx = 3'd4; end
         8'h28: begin is_letter = 1'b1; key_idx = 3'd5; end
         8'h24: begin is_letter = 1'b1; key_idx = 3'd6; end
         8'h22: begin is_letter = 1'b1; key_idx = 3'd7; end
         8'h18:   k_star = 1'b1;
         8'h14:   k_zero = 1'b1;
         8'h12:   k_hash = 1'b1;
         8'h21:   k_game = 1'b1;
         8'h11:   k_case = 1'b1;
         default: ;
      endcase
      accepted = stb_q & (is_letter | k_star | k_zero | k_hash | k_game | k_case);
   end

   always_comb begin
      state_n    = state;
      key_n      = key_r;
      tap_n      = tap_r;
      lower_n    = lower_r;
      ready_n    = 1'b0;
      data_n     = data;
      word_n     = 1'b0;
      game_n     = 1'b0;
      tmr_n      = (state == PEND && tmr != '0) ? tmr - TW'(1) : tmr;
      old_letter = letter_ascii(key_r, tap_r, lower_r);

      if (accepted) begin
         if (is_letter) begin
            tmr_n = RELOAD;
            if (state == PEND && key_idx == key_r) begin
               tap_n = (tap_r == last_tap(key_r)) ? 2'd0 : tap_r + 2'd1;
            end else begin
               if (state == PEND && IMPLICIT_COMMIT) begin
                  ready_n = 1'b1;
                  data_n  = old_letter;
               end
               state_n = PEND;
               key_n   = key_idx;
               tap_n   = 2'd0;
            end
         end else if (k_case) begin
            lower_n = ~lower_r;
            tmr_n   = RELOAD;
         end else if (k_star) begin
            if (state == PEND) begin
               ready_n = 1'b1;
               data_n  = old_letter;
               state_n = IDLE;
               tap_n   = 2'd0;
            end
         end else begin
            // 0, # and C all end the composition; only # keeps the letter
            if (k_hash && state == PEND) begin
               ready_n = 1'b1;
               data_n  = old_letter;
            end
            word_n  = k_hash;
            game_n  = k_game;
            state_n = IDLE;
            tap_n   = 2'd0;
         end
      end else if (TIMEOUT_CYCLES != 0 && state == PEND && tmr == '0) begin
         ready_n = 1'b1;
         data_n  = old_letter;
         state_n = IDLE;
         tap_n   = 2'd0;
      end

      preview_n = (state_n == PEND) ? letter_ascii(key_n, tap_n, lower_n) : 8'h00;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stb_q       <= 1'b0;
         key_q       <= 8'h00;
         state       <= IDLE;
         key_r       <= 3'd0;
         tap_r       <= 2'd0;
         lower_r     <= LOWER_DEFAULT;
         tmr         <= '0;
         ready       <= 1'b0;
         data        <= 8'h00;
         preview     <= 8'h00;
         word_submit <= 1'b0;
         game_end    <= 1'b0;
      end else begin
         stb_q       <= strobe;
         key_q       <= cur_key;
         state       <= state_n;
         key_r       <= key_n;
         tap_r       <= tap_n;
         lower_r     <= lower_n;
         tmr         <= tmr_n;
         ready       <= ready_n;
         data        <= data_n;
         preview     <= preview_n;
         word_submit <= word_n;
         game_end    <= game_n;
      end
   end

   assign pending    = (state == PEND);
   assign tap        = tap_r;
   assign lower_case = lower_r;

endmodule

// File: tb/tb_multitap_letter_encoder.sv
// Bench for multitap_letter_encoder: event-level letter model compared every cycle,
// plus hand-computed literal expectations along the directed key sequences.
module tb_multitap_letter_encoder;

   localparam int unsigned TO   = 8;
   localparam bit          IMPL = 1'b1;
   localparam bit          LDEF = 1'b0;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       strobe = 1'b0;
   logic [7:0] cur_key = 8'h00;
   logic       ready, pending, lower_case, word_submit, game_end;
   logic [7:0] data, preview;
   logic [1:0] tap;

   int n_total = 0;
   int n_pass  = 0;

   multitap_letter_encoder #(
      .TIMEOUT_CYCLES (TO),
      .IMPLICIT_COMMIT(IMPL),
      .LOWER_DEFAULT  (LDEF)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .strobe     (strobe),
      .cur_key    (cur_key),
      .ready      (ready),
      .data       (data),
      .preview    (preview),
      .pending    (pending),
      .tap        (tap),
      .lower_case (lower_case),
      .word_submit(word_submit),
      .game_end   (game_end)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         pend;
      logic [7:0] key;
      int         tap;
      bit         lower;
      int         idle;
      bit         ready;
      logic [7:0] data;
      bit         word;
      bit         game;
   } mdl_t;

   mdl_t m, e;

   function automatic int count_of(logic [7:0] k);
      case (k)
         8'h84, 8'h82, 8'h48, 8'h44, 8'h42, 8'h24: return 3;
         8'h28, 8'h22:                             return 4;
         default:                                  return 0;
      endcase
   endfunction

   function automatic int base_of(logic [7:0] k);
      case (k)
         8'h84: return "A";
         8'h82: return "D";
         8'h48: return "G";
         8'h44: return "J";
         8'h42: return "M";
         8'h28: return "P";
         8'h24: return "T";
         default: return "W";
      endcase
   endfunction

   function automatic logic [7:0] asc(mdl_t s);
      return 8'(base_of(s.key) + s.tap + (s.lower ? 32 : 0));
   endfunction

   function automatic mdl_t mreset();
      mdl_t r;
      r.pend = 0; r.key = 8'h00; r.tap = 0; r.lower = LDEF; r.idle = 0;
      r.ready = 0; r.data = 8'h00; r.word = 0; r.game = 0;
      return r;
   endfunction

   // Zero-latency view of the encoder: one call per clock edge with the raw inputs
   function automatic mdl_t step(mdl_t s, bit stb, logic [7:0] k);
      mdl_t n = s;
      bit   ctrl = (k == 8'h18 || k == 8'h14 || k == 8'h12 || k == 8'h21 || k == 8'h11);
      bit   acc  = stb && (count_of(k) != 0 || ctrl);
      n.ready = 0; n.word = 0; n.game = 0;
      if (acc) begin
         n.idle = 0;
         if (count_of(k) != 0) begin
            if (s.pend && k == s.key) n.tap = (s.tap + 1) % count_of(k);
            else begin
               if (s.pend && IMPL) begin n.ready = 1; n.data = asc(s); end
               n.pend = 1; n.key = k; n.tap = 0;
            end
         end else if (k == 8'h11) n.lower = !s.lower;
         else if (k == 8'h18) begin
            if (s.pend) begin n.ready = 1; n.data = asc(s); end
            n.pend = 0; n.tap = 0;
         end else begin
            if (k == 8'h12 && s.pend) begin n.ready = 1; n.data = asc(s); end
            n.word = (k == 8'h12);
            n.game = (k == 8'h21);
            n.pend = 0; n.tap = 0;
         end
      end else if (s.pend) begin
         n.idle = s.idle + 1;
         if (TO != 0 && n.idle >= int'(TO) - 1) begin
            n.ready = 1; n.data = asc(s); n.pend = 0; n.tap = 0;
         end
      end
      return n;
   endfunction

   function automatic logic [22:0] exp_vec(mdl_t s);
      return {s.ready, s.data, s.pend ? asc(s) : 8'h00, s.pend, 2'(s.tap), s.lower,
              s.word, s.game};
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m <= mreset();
         e <= mreset();
      end else begin
         e <= m;
         m <= step(m, strobe, cur_key);
      end
   end

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h required %h", nm, act, req);
   endtask

   task automatic press(input logic [7:0] k);
      strobe  = 1'b1;
      cur_key = k;
      @(negedge clk);
      strobe  = 1'b0;
      cur_key = 8'h00;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   logic [7:0] seq7 [4];
   logic [7:0] seq9 [5];

   initial begin
      seq7 = '{8'h50, 8'h51, 8'h52, 8'h53};
      seq9 = '{8'h57, 8'h58, 8'h59, 8'h5A, 8'h57};
      fork
         begin : compare_loop
            logic [22:0] act;
            @(posedge clk);
            forever begin
               @(negedge clk);
               act = {ready, data, preview, pending, tap, lower_case, word_submit, game_end};
               n_total++;
               if (act === exp_vec(e)) n_pass++;
               else $display("FAIL cycle_compare @%0t: got %h required %h", $time, act,
                             exp_vec(e));
            end
         end
         begin : stimulus
            repeat (3) @(negedge clk);
            chk("reset_data", data, 8'h00);
            chk("reset_preview", preview, 8'h00);
            chk("reset_flags", {3'd0, ready, pending, lower_case, word_submit, game_end},
                {3'd0, 1'b0, 1'b0, LDEF, 1'b0, 1'b0});
            rst = 1'b0;

            for (int i = 0; i < 4; i++) begin
               press(8'h28); settle();
               chk("key7_preview", preview, seq7[i]);
            end
            press(8'h18); settle();
            chk("star_ready", {7'd0, ready}, 8'h01);
            chk("star_data", data, 8'h53);
            chk("star_idle", {preview[6:0], pending}, 8'h00);
            settle();
            chk("star_single_pulse", {7'd0, ready}, 8'h00);

            for (int i = 0; i < 5; i++) begin
               press(8'h22); settle();
               chk("key9_wrap", preview, seq9[i]);
            end
            press(8'h14); settle();
            for (int i = 0; i < 3; i++) begin
               press(8'h84); settle();
               chk("key2_preview", preview, 8'(8'h41 + i));
               chk("key2_tap", {6'd0, tap}, 8'(i));
            end
            press(8'h14); settle();

            press(8'h84); settle();
            press(8'h82); settle();
            chk("implicit_ready", {7'd0, ready}, 8'h01);
            chk("implicit_data", data, 8'h41);
            chk("implicit_preview", preview, 8'h44);
            press(8'h14); settle();
            chk("clear_preview", preview, 8'h00);
            chk("clear_no_ready", {7'd0, ready}, 8'h00);
            chk("clear_data_kept", data, 8'h41);

            press(8'h44); settle();
            press(8'h44);
            repeat (7) @(negedge clk);
            chk("timeout_early", {7'd0, ready}, 8'h00);
            @(negedge clk);
            chk("timeout_ready", {7'd0, ready}, 8'h01);
            chk("timeout_data", data, 8'h4B);

            press(8'h44); settle();
            press(8'h44);
            repeat (6) @(negedge clk);
            press(8'h44); settle();
            chk("expiry_strobe_no_ready", {7'd0, ready}, 8'h00);
            chk("expiry_strobe_preview", preview, 8'h4C);
            press(8'h14); settle();

            press(8'h44); settle();
            press(8'h44);
            press(8'h88);
            press(8'h81);
            press(8'h41);
            press(8'hC3);
            repeat (3) @(negedge clk);
            chk("ignored_no_extend_early", {7'd0, ready}, 8'h00);
            @(negedge clk);
            chk("ignored_no_extend_ready", {7'd0, ready}, 8'h01);
            chk("ignored_no_extend_data", data, 8'h4B);

            press(8'h11); settle();
            chk("case_toggle", {7'd0, lower_case}, 8'h01);
            press(8'h24); settle();
            chk("lower_preview", preview, 8'h74);
            press(8'h12); settle();
            chk("hash_pulses", {6'd0, ready, word_submit}, 8'h03);
            chk("hash_data", data, 8'h74);
            press(8'h42); settle();
            chk("lower_m_preview", preview, 8'h6D);
            press(8'h21); settle();
            chk("game_end_flags", {6'd0, game_end, ready}, 8'h02);
            chk("game_end_preview", preview, 8'h00);

            press(8'h11); settle();
            press(8'h48); settle();
            chk("key4_preview", preview, 8'h47);
            rst = 1'b1; strobe = 1'b1; cur_key = 8'h48;
            @(negedge clk);
            rst = 1'b0; strobe = 1'b0; cur_key = 8'h00;
            chk("rst_preview", preview, 8'h00);
            chk("rst_data", data, 8'h00);
            chk("rst_flags", {4'd0, ready, pending, lower_case, game_end}, 8'h00);
            settle();
            chk("rst_no_ready", {7'd0, ready}, 8'h00);
            press(8'h48); settle();
            chk("restart_preview", preview, 8'h47);
            chk("restart_tap", {6'd0, tap}, 8'h00);
            repeat (12) @(negedge clk);
         end
      join_any
      disable fork;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
